// File: rtl/sys_skew_buffer.sv
// ---------------------------------------------------------------------------
// sys_skew_buffer
//
// Diagonal skew stage between the setup controller's operand stream and one
// input port of the systolic array (one instance for weights, one for the
// matrix operand). Each input word is split into LANES byte lanes. Lane i is
// delayed i+1 register stages, so the word enters the array as a diagonal
// wavefront. The stream's last flag travels through its own LANES-deep
// tracker, so out_last lines up with lane LANES-1 of the final word.
//
// Flow control:
//   in_valid qualifies in_data/in_mask/in_last in the cycle it is high. A
//   word is accepted on a posedge where in_valid=1 and stall=0. There is no
//   ready output. While stall=1 every register holds, nothing is captured,
//   and the upstream keeps presenting the same word until stall drops.
//
// Ports:
//   clk            clock; all state updates on posedge
//   rst            asynchronous active-low reset
//   in_data        operand word, lane i = in_data[i*LANE_W +: LANE_W]
//   in_mask        bitwise data mask, same lane layout
//   in_valid       in_data/in_mask/in_last qualified
//   in_last        final word of the current stream (ignored without in_valid)
//   stall          freeze all registers while high
//   out_data       skewed lanes to the array (registered)
//   out_lane_valid per-lane valid (registered)
//   out_last       pulse aligned with lane LANES-1 of the in_last word
//   busy           any valid lane element or last flag still in flight
//
// WORD_SIZE must equal LANES*LANE_W.
// ---------------------------------------------------------------------------
module sys_skew_buffer #(
  parameter int LANES     = 16,
  parameter int LANE_W    = 8,
  parameter int WORD_SIZE = 128
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] in_data,
  input  logic [WORD_SIZE-1:0] in_mask,
  input  logic                 in_valid,
  input  logic                 in_last,
  input  logic                 stall,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [LANES-1:0]     out_lane_valid,
  output logic                 out_last,
  output logic                 busy
);

  // Per-lane "something valid in this lane's shift register".
  logic [LANES-1:0] lane_busy;

  // Last-flag tracker: stage 0 takes the qualified flag, final stage is
  // out_last. Same depth as lane LANES-1, hence aligned with it.
  logic [LANES-1:0] last_sr;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    localparam int DEPTH = gi + 1;

    logic [LANE_W-1:0] q_data;
    logic              q_lv;
    logic [LANE_W-1:0] d_sr [DEPTH];
    logic [DEPTH-1:0]  v_sr;

    // Qualified lane input: masked data, and a lane valid only when at
    // least one data bit of the lane survives the mask.
    always_comb begin
      q_data = '0;
      q_lv   = 1'b0;
      if (in_valid) begin
        q_data = in_data[gi*LANE_W +: LANE_W] & in_mask[gi*LANE_W +: LANE_W];
        q_lv   = |in_mask[gi*LANE_W +: LANE_W];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_sr <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          d_sr[k] <= '0;
        end
      end else if (!stall) begin
        d_sr[0] <= q_data;
        v_sr[0] <= q_lv;
        for (int k = 1; k < DEPTH; k++) begin
          d_sr[k] <= d_sr[k-1];
          v_sr[k] <= v_sr[k-1];
        end
      end
    end

    assign out_data[gi*LANE_W +: LANE_W] = d_sr[DEPTH-1];
    assign out_lane_valid[gi]            = v_sr[DEPTH-1];
    assign lane_busy[gi]                 = |v_sr;
  end

  // A fully masked word still advances the tracker, so its in_last is kept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_sr <= '0;
    end else if (!stall) begin
      last_sr <= {last_sr[LANES-2:0], in_valid & in_last};
    end
  end

  assign out_last = last_sr[LANES-1];

  // OR of register bits only; drops in the cycle after the final element
  // leaves the last stage of lane LANES-1.
  assign busy = (|lane_busy) | (|last_sr);

endmodule

// File: tb/tb_sys_skew_buffer.sv
// ---------------------------------------------------------------------------
// tb_sys_skew_buffer
//
// Directed bench for sys_skew_buffer (LANES=16, LANE_W=8). Inputs are changed
// and outputs sampled 1ns after each rising edge. "Sample k" means the sample
// after the k-th posedge counted from the posedge that captured the first word
// of the scenario (k=0 is the capture edge itself).
// ---------------------------------------------------------------------------
module tb_sys_skew_buffer;

  localparam int LANES  = 16;
  localparam int LANE_W = 8;
  localparam int WS     = LANES * LANE_W;

  logic          clk;
  logic          rst;
  logic [WS-1:0] in_data;
  logic [WS-1:0] in_mask;
  logic          in_valid;
  logic          in_last;
  logic          stall;
  logic [WS-1:0] out_data;
  logic [LANES-1:0] out_lane_valid;
  logic          out_last;
  logic          busy;

  int tests_run;
  int tests_failed;

  sys_skew_buffer #(.LANES(LANES), .LANE_W(LANE_W), .WORD_SIZE(WS)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_mask        (in_mask),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .stall          (stall),
    .out_data       (out_data),
    .out_lane_valid (out_lane_valid),
    .out_last       (out_last),
    .busy           (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish before it");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    in_data  = '0;
    in_mask  = '0;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Distinct, nonzero value per (word, lane) so lane swaps or word slips show.
  function automatic logic [7:0] lane_val(input int w, input int i);
    return 8'(((w + 1) << 4) | i);
  endfunction

  task automatic drive_word(input int w, input logic last);
    for (int i = 0; i < LANES; i++) in_data[i*LANE_W +: LANE_W] = lane_val(w, i);
    in_mask  = '1;
    in_valid = 1'b1;
    in_last  = last;
  endtask

  // Expected lanes after e effective shifts for a run of nwords words
  // captured on consecutive shifts 0..nwords-1 (full masks).
  function automatic void exp_model(input int e, input int nwords,
                                    output logic [WS-1:0] d, output logic [LANES-1:0] v);
    d = '0;
    v = '0;
    for (int i = 0; i < LANES; i++) begin
      if (e - i >= 0 && e - i < nwords) begin
        d[i*LANE_W +: LANE_W] = lane_val(e - i, i);
        v[i] = 1'b1;
      end
    end
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0;
    stall = 1'b0;
    drive_idle();
    step();
    step();
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL reset_data: got %h want 0", out_data); end
    tests_run++; if (out_lane_valid !== '0) begin tests_failed++; $display("FAIL reset_lv: got %h want 0", out_lane_valid); end
    tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_last: got %b want 0", out_last); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    rst = 1'b1;
    step();
  endtask

  task automatic test_single_word();
    logic [WS-1:0]    ed;
    logic [LANES-1:0] ev;
    for (int i = 0; i < LANES; i++) in_data[i*LANE_W +: LANE_W] = 8'(i + 1);
    in_mask = '1; in_valid = 1'b1; in_last = 1'b1;
    step();
    drive_idle();
    for (int k = 0; k <= LANES; k++) begin
      ed = '0;
      ev = '0;
      if (k < LANES) begin
        ed[k*LANE_W +: LANE_W] = 8'(k + 1);
        ev[k] = 1'b1;
      end
      tests_run++; if (out_data !== ed) begin tests_failed++; $display("FAIL single_data k=%0d: got %h want %h", k, out_data, ed); end
      tests_run++; if (out_lane_valid !== ev) begin tests_failed++; $display("FAIL single_lv k=%0d: got %h want %h", k, out_lane_valid, ev); end
      tests_run++; if (out_last !== (k == LANES-1)) begin tests_failed++; $display("FAIL single_last k=%0d: got %b want %b", k, out_last, (k == LANES-1)); end
      tests_run++; if (busy !== (k < LANES)) begin tests_failed++; $display("FAIL single_busy k=%0d: got %b want %b", k, busy, (k < LANES)); end
      step();
    end
  endtask

  task automatic test_masking();
    logic [WS-1:0]    ed;
    logic [LANES-1:0] ev;
    in_data = {LANES{8'hAA}};
    in_mask = {8'h00, {(LANES-1){8'hFF}}};
    in_valid = 1'b1; in_last = 1'b1;
    step();
    drive_idle();
    for (int k = 0; k <= LANES; k++) begin
      ed = '0;
      ev = '0;
      if (k < LANES-1) begin
        ed[k*LANE_W +: LANE_W] = 8'hAA;
        ev[k] = 1'b1;
      end
      tests_run++; if (out_data !== ed) begin tests_failed++; $display("FAIL mask_data k=%0d: got %h want %h", k, out_data, ed); end
      tests_run++; if (out_lane_valid !== ev) begin tests_failed++; $display("FAIL mask_lv k=%0d: got %h want %h", k, out_lane_valid, ev); end
      tests_run++; if (out_last !== (k == LANES-1)) begin tests_failed++; $display("FAIL mask_last k=%0d: got %b want %b", k, out_last, (k == LANES-1)); end
      tests_run++; if (busy !== (k < LANES)) begin tests_failed++; $display("FAIL mask_busy k=%0d: got %b want %b", k, busy, (k < LANES)); end
      step();
    end
  endtask

  // Stream A = words 0..2 (last on 2), stream B = words 3..4 (last on 4).
  task automatic test_back_to_back();
    logic [WS-1:0]    ed;
    logic [LANES-1:0] ev;
    logic             el;
    int               nlast;
    nlast = 0;
    drive_word(0, 1'b0);
    step();
    for (int k = 0; k <= 21; k++) begin
      exp_model(k, 5, ed, ev);
      el = (k == 17) || (k == 19);
      if (out_last === 1'b1) nlast++;
      tests_run++; if (out_data !== ed) begin tests_failed++; $display("FAIL b2b_data k=%0d: got %h want %h", k, out_data, ed); end
      tests_run++; if (out_lane_valid !== ev) begin tests_failed++; $display("FAIL b2b_lv k=%0d: got %h want %h", k, out_lane_valid, ev); end
      tests_run++; if (out_last !== el) begin tests_failed++; $display("FAIL b2b_last k=%0d: got %b want %b", k, out_last, el); end
      tests_run++; if (busy !== (k <= 19)) begin tests_failed++; $display("FAIL b2b_busy k=%0d: got %b want %b", k, busy, (k <= 19)); end
      if (k + 1 < 5) drive_word(k + 1, (k + 1 == 2) || (k + 1 == 4));
      else drive_idle();
      step();
    end
    tests_run++; if (nlast !== 2) begin tests_failed++; $display("FAIL b2b_last_count: got %0d want 2", nlast); end
  endtask

  // Four words (last on word 3); stall freezes posedges 5, 6 and 7.
  task automatic test_stall();
    logic [WS-1:0]    ed;
    logic [LANES-1:0] ev;
    int               frozen;
    int               e;
    drive_word(0, 1'b0);
    step();
    for (int k = 0; k <= 23; k++) begin
      frozen = (k < 5) ? 0 : ((k - 4 > 3) ? 3 : k - 4);
      e = k - frozen;
      exp_model(e, 4, ed, ev);
      tests_run++; if (out_data !== ed) begin tests_failed++; $display("FAIL stall_data k=%0d: got %h want %h", k, out_data, ed); end
      tests_run++; if (out_lane_valid !== ev) begin tests_failed++; $display("FAIL stall_lv k=%0d: got %h want %h", k, out_lane_valid, ev); end
      tests_run++; if (out_last !== (k == 21)) begin tests_failed++; $display("FAIL stall_last k=%0d: got %b want %b", k, out_last, (k == 21)); end
      tests_run++; if (busy !== (e <= 18)) begin tests_failed++; $display("FAIL stall_busy k=%0d: got %b want %b", k, busy, (e <= 18)); end
      if (k + 1 < 4) drive_word(k + 1, (k + 1 == 3));
      else drive_idle();
      stall = (k >= 4) && (k <= 6);
      step();
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_stream();
    drive_word(0, 1'b0);
    step();
    for (int k = 0; k < 5; k++) begin
      drive_word(k + 1, 1'b0);
      step();
    end
    // Sample 5: six words in flight, lane 0 showing word 5.
    tests_run++; if (out_lane_valid[0] !== 1'b1) begin tests_failed++; $display("FAIL rmid_pre_lv0: got %b want 1", out_lane_valid[0]); end
    rst = 1'b0;
    #1;
    tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL rmid_async_data: got %h want 0", out_data); end
    tests_run++; if (out_lane_valid !== '0) begin tests_failed++; $display("FAIL rmid_async_lv: got %h want 0", out_lane_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_async_busy: got %b want 0", busy); end
    drive_idle();
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      tests_run++; if (out_lane_valid !== '0) begin tests_failed++; $display("FAIL rmid_lv k=%0d: got %h want 0", k, out_lane_valid); end
      tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL rmid_last k=%0d: got %b want 0", k, out_last); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL rmid_busy k=%0d: got %b want 0", k, busy); end
    end
  endtask

  task automatic test_invalid_last();
    in_data  = {LANES{8'h5C}};
    in_mask  = '1;
    in_valid = 1'b0;
    in_last  = 1'b1;
    step();
    drive_idle();
    for (int k = 0; k < 18; k++) begin
      tests_run++; if (out_lane_valid !== '0) begin tests_failed++; $display("FAIL invlast_lv k=%0d: got %h want 0", k, out_lane_valid); end
      tests_run++; if (out_last !== 1'b0) begin tests_failed++; $display("FAIL invlast_last k=%0d: got %b want 0", k, out_last); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL invlast_busy k=%0d: got %b want 0", k, busy); end
      tests_run++; if (out_data !== '0) begin tests_failed++; $display("FAIL invlast_data k=%0d: got %h want 0", k, out_data); end
      step();
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_single_word();
    test_masking();
    test_back_to_back();
    test_stall();
    test_reset_mid_stream();
    test_invalid_last();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
